// File: rtl/snake_pkg.sv
// Shared snake-game definitions: screen geometry, plot record layout and
// arbiter state encodings used by both the snake logic and the plot arbiter.
package snake_pkg;

    localparam int unsigned SCREEN_W_DEF   = 160;
    localparam int unsigned SCREEN_H_DEF   = 120;
    localparam int unsigned FIFO_DEPTH_DEF = 16;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } plot_t;

    localparam int unsigned PLOT_W = $bits(plot_t);

    function automatic logic on_screen(input logic [X_W-1:0] px,
                                       input logic [Y_W-1:0] py,
                                       input int unsigned    w,
                                       input int unsigned    h);
        return (32'(px) < w) && (32'(py) < h);
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Plot request FIFO: synchronous push/pop, show-ahead head, occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module plot_fifo
    import snake_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [PLOT_W-1:0]      data_i,
    input  logic                   pop_i,
    output logic [PLOT_W-1:0]      data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [PLOT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/plot_arbiter.sv
// Arbitrates VGA writes between queued snake plots and a full-screen clear
// sweep; all VGA-facing outputs are registered.
module plot_arbiter
    import snake_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H   = SCREEN_H_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                plotEn_in,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                writeEn,
    output logic                full,
    output logic                busy,
    output logic                overflow,
    output logic                clear_done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    arb_state_e          state_q;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                writeEn_q;
    logic                overflow_q;
    logic                clear_done_q;
    logic [X_W-1:0]      clr_x_q;
    logic [X_W-1:0]      clr_x_d;
    logic [Y_W-1:0]      clr_y_q;
    logic [Y_W-1:0]      clr_y_d;
    logic [COLOUR_W-1:0] clr_colour_q;

    plot_t                        in_plot;
    plot_t                        head_plot;
    logic [PLOT_W-1:0]            head_bits;
    logic [$clog2(FIFO_DEPTH):0]  occupancy;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         in_range;
    logic                         push_req;
    logic                         can_pop;
    logic                         drop;
    logic                         clr_last;

    assign in_plot   = '{x: x_in, y: y_in, colour: colour_in};
    assign head_plot = head_bits;

    // Pops are decided from state alone, so a push into a full FIFO can
    // safely ride on the same-edge pop without a combinational loop.
    always_comb begin
        in_range = on_screen(x_in, y_in, SCREEN_W, SCREEN_H);
        push_req = plotEn_in && in_range;
        can_pop  = (state_q != ST_CLEAR) && !fifo_empty && !clear_req;
        drop     = push_req && fifo_full && !can_pop;
        clr_last = (clr_x_q == X_LAST) && (clr_y_q == Y_LAST);
        if (clr_x_q == X_LAST) begin
            clr_x_d = '0;
            clr_y_d = clr_y_q + 1'b1;
        end else begin
            clr_x_d = clr_x_q + 1'b1;
            clr_y_d = clr_y_q;
        end
    end

    plot_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_req),
        .data_i  (in_plot),
        .pop_i   (can_pop),
        .data_o  (head_bits),
        .count_o (occupancy),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            writeEn_q    <= 1'b0;
            overflow_q   <= 1'b0;
            clear_done_q <= 1'b0;
            clr_x_q      <= '0;
            clr_y_q      <= '0;
            clr_colour_q <= '0;
        end else begin
            clear_done_q <= 1'b0;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE, ST_DRAIN: begin
                    if (clear_req) begin
                        // Pixel (0,0) goes out on the entry edge itself.
                        state_q      <= ST_CLEAR;
                        clr_x_q      <= '0;
                        clr_y_q      <= '0;
                        clr_colour_q <= clear_colour;
                        x_q          <= '0;
                        y_q          <= '0;
                        colour_q     <= clear_colour;
                        writeEn_q    <= 1'b1;
                    end else if (can_pop) begin
                        state_q   <= ST_DRAIN;
                        x_q       <= head_plot.x;
                        y_q       <= head_plot.y;
                        colour_q  <= head_plot.colour;
                        writeEn_q <= 1'b1;
                    end else begin
                        state_q   <= ST_IDLE;
                        writeEn_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_last) begin
                        state_q      <= ST_IDLE;
                        writeEn_q    <= 1'b0;
                        clear_done_q <= 1'b1;
                    end else begin
                        clr_x_q   <= clr_x_d;
                        clr_y_q   <= clr_y_d;
                        x_q       <= clr_x_d;
                        y_q       <= clr_y_d;
                        colour_q  <= clr_colour_q;
                        writeEn_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    writeEn_q <= 1'b0;
                end
            endcase
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign writeEn    = writeEn_q;
    assign overflow   = overflow_q;
    assign clear_done = clear_done_q;
    assign full       = fifo_full;
    assign busy       = (state_q == ST_CLEAR) || (occupancy != '0) || writeEn_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Self-checking bench for plot_arbiter: a queue-based reference model checked
// every cycle, a vector table for single plots, and directed clear/overflow/reset sequences.
module tb_plot_arbiter;

    localparam int W = 160;
    localparam int H = 120;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       plotEn_in = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [2:0] colour_in = '0;
    logic       clear_req = 1'b0;
    logic [2:0] clear_colour = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn, full, busy, overflow, clear_done;

    always #5 clk = ~clk;

    plot_arbiter #(
        .FIFO_DEPTH (D),
        .SCREEN_W   (W),
        .SCREEN_H   (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .plotEn_in    (plotEn_in),
        .x_in         (x_in),
        .y_in         (y_in),
        .colour_in    (colour_in),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .writeEn      (writeEn),
        .full         (full),
        .busy         (busy),
        .overflow     (overflow),
        .clear_done   (clear_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model: pending-plot queue + linear clear index
    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t mq[$];
    pix_t m_p;
    bit   m_clearing = 0;
    int   m_idx = 0;
    int   m_ccol = 0;
    int   m_x = 0, m_y = 0, m_c = 0;
    bit   m_we = 0, m_ovf = 0, m_done = 0;
    bit   m_inr, m_was_full, m_can_pop;
    bit   chk_en = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_clearing = 0;
            m_idx = 0;
            m_x = 0; m_y = 0; m_c = 0;
            m_we = 0; m_ovf = 0; m_done = 0;
        end else begin
            m_inr      = (int'(x_in) < W) && (int'(y_in) < H);
            m_was_full = (mq.size() == D);
            m_can_pop  = !m_clearing && (mq.size() > 0) && !clear_req;
            m_done = 0;
            if (m_clearing) begin
                if (m_idx == W*H - 1) begin
                    m_clearing = 0;
                    m_we = 0;
                    m_done = 1;
                end else begin
                    m_idx++;
                    m_x = m_idx % W;
                    m_y = m_idx / W;
                    m_c = m_ccol;
                    m_we = 1;
                end
            end else if (clear_req) begin
                m_clearing = 1;
                m_idx = 0;
                m_ccol = int'(clear_colour);
                m_x = 0; m_y = 0; m_c = m_ccol;
                m_we = 1;
            end else if (m_can_pop) begin
                m_p = mq.pop_front();
                m_x = m_p.x; m_y = m_p.y; m_c = m_p.c;
                m_we = 1;
            end else begin
                m_we = 0;
            end
            if (plotEn_in && m_inr) begin
                if (!m_was_full || m_can_pop)
                    mq.push_back('{int'(x_in), int'(y_in), int'(colour_in)});
                else
                    m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_cycle",
                  {9'd0, x, y, colour, writeEn, full, busy, overflow, clear_done},
                  {9'd0, 8'(m_x), 7'(m_y), 3'(m_c), m_we, (mq.size() == D),
                   (m_clearing || mq.size() > 0 || m_we), m_ovf, m_done});
        end
    end

    // ---------------- single-plot vector table
    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       we;
    } vec_t;

    vec_t tbl[6];

    int         n;
    bit         seen_done, early, prev_we, done_after_last, found, any_bad;
    logic [14:0] last_xy;

    initial begin
        tbl[0] = '{8'd60,  7'd60,  3'd2, 1'b1};
        tbl[1] = '{8'd160, 7'd5,   3'd1, 1'b0};
        tbl[2] = '{8'd5,   7'd120, 3'd7, 1'b0};
        tbl[3] = '{8'd0,   7'd0,   3'd5, 1'b1};
        tbl[4] = '{8'd159, 7'd119, 3'd6, 1'b1};
        tbl[5] = '{8'd255, 7'd127, 3'd3, 1'b0};

        // reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_writeEn", writeEn, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_overflow", overflow, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        rst = 1'b0;
        chk_en = 1;
        tick();

        // single plots: written exactly two edges after the push edge
        for (int i = 0; i < 6; i++) begin
            plotEn_in = 1'b1;
            x_in = tbl[i].x; y_in = tbl[i].y; colour_in = tbl[i].c;
            tick();
            plotEn_in = 1'b0;
            check("tbl_no_early_we", writeEn, 0);
            tick();
            check("tbl_we", writeEn, tbl[i].we);
            if (tbl[i].we) begin
                check("tbl_x", x, tbl[i].x);
                check("tbl_y", y, tbl[i].y);
                check("tbl_colour", colour, tbl[i].c);
            end
            tick();
            check("tbl_we_after", writeEn, 0);
            check("tbl_busy_after", busy, 0);
            check("tbl_overflow", overflow, 0);
            tick();
        end

        // clear with coincident plot (10,20): plot must follow the whole sweep
        clear_req = 1'b1; clear_colour = 3'd0;
        plotEn_in = 1'b1; x_in = 8'd10; y_in = 7'd20; colour_in = 3'd5;
        tick();
        clear_req = 1'b0; plotEn_in = 1'b0;
        n = 0; seen_done = 0; early = 0; prev_we = 0; done_after_last = 0; last_xy = '0;
        for (int i = 0; i < 20000 && !seen_done; i++) begin
            if (writeEn) begin
                if (n == 0) begin
                    check("clr_first_x", x, 0);
                    check("clr_first_y", y, 0);
                    check("clr_first_colour", colour, 0);
                end
                if (colour == 3'd5) early = 1;
                last_xy = {x, y};
                n++;
            end
            if (clear_done) begin
                seen_done = 1;
                done_after_last = prev_we;
            end
            prev_we = writeEn;
            if (!seen_done) tick();
        end
        check("clr_done_seen", seen_done, 1);
        check("clr_pixel_count", n, W*H);
        check("clr_last_xy", last_xy, {8'd159, 7'd119});
        check("clr_done_follows_last", done_after_last, 1);
        check("clr_plot_not_early", early, 0);
        tick();
        check("clr_done_one_cycle", clear_done, 0);
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (writeEn) found = 1;
            else tick();
        end
        check("clr_plot_written", found, 1);
        check("clr_plot_x", x, 10);
        check("clr_plot_y", y, 20);
        check("clr_plot_colour", colour, 5);
        repeat (4) tick();

        // overflow: streaming pushes never overflow; pushes during a clear do
        for (int i = 0; i < 20; i++) begin
            plotEn_in = 1'b1;
            x_in = 8'($urandom_range(0, W-1));
            y_in = 7'($urandom_range(0, H-1));
            colour_in = 3'($urandom);
            tick();
        end
        plotEn_in = 1'b0;
        repeat (4) tick();
        check("ovf_stream_none", overflow, 0);
        clear_req = 1'b1; clear_colour = 3'd4;
        tick();
        clear_req = 1'b0;
        for (int i = 0; i < 17; i++) begin
            plotEn_in = 1'b1;
            x_in = 8'(i); y_in = 7'(i); colour_in = 3'(i);
            tick();
            if (i == 15) check("ovf_full_at_16", full, 1);
        end
        plotEn_in = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_full", full, 1);
        seen_done = 0;
        for (int i = 0; i < 20000 && !seen_done; i++) begin
            if (clear_done) seen_done = 1;
            else tick();
        end
        check("ovf_clear_done", seen_done, 1);
        repeat (30) tick();
        check("ovf_sticky", overflow, 1);
        check("ovf_drained_busy", busy, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovf_cleared_by_rst", overflow, 0);
        tick();

        // reset in the middle of a clear, with plots queued behind it
        clear_req = 1'b1; clear_colour = 3'd1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 500; k++) begin
            plotEn_in = (k < 3);
            x_in = 8'd30; y_in = 7'd40; colour_in = 3'd6;
            tick();
        end
        plotEn_in = 1'b0;
        check("mid_clr_x", x, 20);
        check("mid_clr_y", y, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_we", writeEn, 0);
        check("mid_rst_done", clear_done, 0);
        check("mid_rst_full", full, 0);
        check("mid_rst_busy", busy, 0);
        any_bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (writeEn || clear_done) any_bad = 1;
        end
        check("mid_rst_quiet", any_bad, 0);

        // random traffic with occasional resets, model-checked every cycle
        for (int i = 0; i < 1500; i++) begin
            plotEn_in = ($urandom_range(0, 1) == 1);
            x_in = 8'($urandom_range(0, 175));
            y_in = 7'($urandom_range(0, 127));
            colour_in = 3'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;

        // random traffic across a clear started mid-drain; clear_req retriggers ignored
        seen_done = 0;
        for (int i = 0; i < 21000 && !seen_done; i++) begin
            plotEn_in = ($urandom_range(0, 3) != 0);
            x_in = 8'($urandom_range(0, 170));
            y_in = 7'($urandom_range(0, 125));
            colour_in = 3'($urandom);
            clear_colour = 3'($urandom);
            clear_req = (i == 60) || (m_clearing && $urandom_range(0, 49) == 0);
            tick();
            if (clear_done) seen_done = 1;
        end
        clear_req = 1'b0;
        check("rand_clear_done", seen_done, 1);
        for (int i = 0; i < 100; i++) begin
            plotEn_in = ($urandom_range(0, 1) == 1);
            x_in = 8'($urandom_range(0, W-1));
            y_in = 7'($urandom_range(0, H-1));
            tick();
        end
        plotEn_in = 1'b0;
        repeat (40) tick();
        check("final_busy", busy, 0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: plotEn_in  input  1  plot request strobe from the snake logic stage.
REQ-004 SHALL have ports: x_in  input  8  pixel column; y_in  input  7  pixel row; colour_in  input  3  pixel colour.
REQ-005 SHALL have ports: clear_req  input  1  start full-screen clear; clear_colour  input  3  colour used for the clear.
REQ-006 SHALL have ports: x  output  8; y  output  7; colour  output  3; writeEn  output  1, all driving the VGA adapter.
REQ-007 SHALL have ports: full  output  1  FIFO full; busy  output  1  clear in progress or FIFO non-empty; overflow  output  1  sticky drop flag; clear_done  output  1  one-cycle pulse.
REQ-008 SHALL have parameters: FIFO_DEPTH, default 16, plot FIFO entries (power of two); SCREEN_W, default 160, columns; SCREEN_H, default 120, rows.

Function
REQ-009 SHALL implement states IDLE, DRAIN, CLEAR; IDLE->DRAIN when FIFO non-empty; DRAIN->IDLE when FIFO empty after a pop; IDLE or DRAIN->CLEAR on clear_req; CLEAR->IDLE after final clear pixel.
REQ-010 SHALL push {x_in, y_in, colour_in} when plotEn_in=1, full=0, x_in<SCREEN_W and y_in<SCREEN_H, in any state, including CLEAR.
REQ-011 SHALL discard out-of-range requests (x_in>=SCREEN_W or y_in>=SCREEN_H) silently, without setting overflow.
REQ-012 SHALL discard an in-range request when full=1 and set overflow, which stays 1 until rst.
REQ-013 SHALL pop at most one entry per cycle in DRAIN; popped entry appears on x/y/colour with writeEn=1 on the cycle after the pop edge (registered outputs).
REQ-014 SHALL present an entry pushed at edge E into an empty FIFO in IDLE with writeEn=1 during the cycle following edge E+1 (two-edge latency).
REQ-015 SHALL support simultaneous push and pop without changing occupancy; a pop with full=1 and a concurrent push both succeed.
REQ-016 SHALL, in CLEAR, emit one pixel per cycle with writeEn=1 and colour=clear_colour (sampled at CLEAR entry), row-major: x 0..SCREEN_W-1 inner, y 0..SCREEN_H-1 outer; total SCREEN_W*SCREEN_H cycles.
REQ-017 SHALL not pop the FIFO during CLEAR; queued plots drain after clear, so they overwrite cleared pixels.
REQ-018 SHALL ignore clear_req while in CLEAR (no restart).
REQ-019 SHALL, on clear_req in DRAIN, complete the current output cycle, then enter CLEAR with the remaining entries held.
REQ-020 SHALL, when clear_req and plotEn_in coincide, enqueue the plot and begin CLEAR on the next cycle.
REQ-021 SHALL pulse clear_done for exactly one cycle, the cycle after the writeEn cycle of pixel (SCREEN_W-1, SCREEN_H-1).
REQ-022 SHALL hold writeEn=0 in IDLE; x/y/colour SHALL hold their last values when writeEn=0.
REQ-023 SHALL drive full combinationally from occupancy==FIFO_DEPTH; busy=1 in CLEAR or when occupancy>0 or writeEn=1.

Reset
REQ-024 SHALL, with rst=1 at an edge, set state IDLE, FIFO empty, clear counters 0, x=0, y=0, colour=0, writeEn=0, overflow=0, clear_done=0.
REQ-025 SHALL, on rst mid-CLEAR or mid-DRAIN, abort immediately: queued entries lost, no clear_done pulse.

Structure
REQ-026 SHALL place SCREEN_W, SCREEN_H, FIFO_DEPTH defaults and state encodings in a shared snake package reused by the snake logic stage.
REQ-027 SHALL implement storage as one sub-module plot_fifo (synchronous push/pop, occupancy count, full/empty); FSM and clear counters stay in plot_arbiter.

Verification
REQ-028 SHALL test single plot: push (60,60,3'b010) in IDLE -> writeEn=1 with x=60,y=60,colour=2 exactly two edges later, then IDLE.
REQ-029 SHALL test overflow: 20 consecutive in-range pushes, no drain stall -> 16 retained plus drains, overflow remains 0; then block drain via CLEAR and push 17 -> overflow=1 and stays 1 until rst.
REQ-030 SHALL test clear: clear_req with clear_colour=0 -> 19200 consecutive writeEn cycles, first (0,0), last (159,119), clear_done one cycle later.
REQ-031 SHALL test clear_req coincident with push (10,20) -> (10,20) written after the 19200 clear pixels, not before.
REQ-032 SHALL test out-of-range push (160,5) and (5,120) -> no writeEn, overflow=0.
REQ-033 SHALL test rst asserted at clear pixel 500 -> writeEn=0 next cycle, no clear_done, FIFO empty.
